// File: rtl/seq_detect_param.sv
// Parametrised serial-pattern detector with KMP-style prefix tracking, match pulse/stretch and counter.
// Optional runtime pattern load is enabled by defining SEQ_DETECT_PATTERN_LOAD_EN.
module seq_detect_param #(
    parameter int unsigned      PAT_W   = 7,
    parameter logic [PAT_W-1:0] PATTERN = 7'b1100111,
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      HIST_W  = 10,
    parameter int unsigned      CNT_W   = 8,
    parameter int unsigned      STRETCH = 25000000
) (
    input  logic                       CLOCK_50,
    input  logic                       KEY0,
`ifdef SEQ_DETECT_PATTERN_LOAD_EN
    input  logic                       pat_load,
    input  logic [PAT_W-1:0]           pat_in,
`endif
    input  logic                       bit_in,
    input  logic                       bit_valid,
    input  logic                       clr,
    output logic                       match,
    output logic                       match_led,
    output logic [$clog2(PAT_W+1)-1:0] progress,
    output logic [HIST_W-1:0]          history,
    output logic [CNT_W-1:0]           match_count
);

    localparam int unsigned PROG_W = $clog2(PAT_W + 1);
    localparam int unsigned TMR_W  = $clog2(STRETCH + 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(STRETCH);
    localparam logic [PROG_W-1:0] FULL     = PROG_W'(PAT_W);

    logic [PAT_W-1:0]  pat;
    logic [PAT_W-1:0]  window, window_shift, window_next;
    logic [PROG_W-1:0] vcnt, vcnt_shift, vcnt_next;
    logic [PROG_W-1:0] k_next, progress_next;
    logic [HIST_W-1:0] history_next;
    logic [CNT_W-1:0]  count_next;
    logic [TMR_W-1:0]  timer, timer_next;
    logic              match_next;
    logic              hit;

`ifdef SEQ_DETECT_PATTERN_LOAD_EN
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0)
            pat <= PATTERN;
        else if (!clr && pat_load)
            pat <= pat_in;
    end
`else
    assign pat = PATTERN;
`endif

    // Longest k <= vcnt whose newest k window bits equal the first k pattern bits;
    // ascending scan so the last hit is the largest.
    always_comb begin
        window_shift = {window[PAT_W-2:0], bit_in};
        vcnt_shift   = (vcnt == FULL) ? FULL : vcnt + 1'b1;
        k_next       = '0;
        hit          = 1'b0;
        for (int unsigned k = 1; k <= PAT_W; k++) begin
            hit = (PROG_W'(k) <= vcnt_shift);
            for (int unsigned i = 0; i < k; i++) begin
                if (window_shift[i] != pat[PAT_W - k + i])
                    hit = 1'b0;
            end
            if (hit)
                k_next = PROG_W'(k);
        end
    end

    always_comb begin
        window_next   = window;
        vcnt_next     = vcnt;
        progress_next = progress;
        history_next  = history;
        count_next    = match_count;
        match_next    = 1'b0;
        timer_next    = (timer != '0) ? timer - 1'b1 : '0;

        if (clr) begin
            vcnt_next     = '0;
            progress_next = '0;
            history_next  = '0;
            count_next    = '0;
        end
`ifdef SEQ_DETECT_PATTERN_LOAD_EN
        else if (pat_load) begin
            vcnt_next     = '0;
            progress_next = '0;
        end
`endif
        else if (bit_valid) begin
            window_next   = window_shift;
            vcnt_next     = vcnt_shift;
            progress_next = k_next;
            history_next  = {history[HIST_W-2:0], bit_in};
            if (k_next == FULL) begin
                match_next = 1'b1;
                timer_next = TMR_LOAD;
                if (match_count != '1)
                    count_next = match_count + 1'b1;
                if (!OVERLAP)
                    vcnt_next = '0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            window      <= '0;
            vcnt        <= '0;
            progress    <= '0;
            history     <= '0;
            match_count <= '0;
            match       <= 1'b0;
            timer       <= '0;
            match_led   <= 1'b0;
        end else begin
            window      <= window_next;
            vcnt        <= vcnt_next;
            progress    <= progress_next;
            history     <= history_next;
            match_count <= count_next;
            match       <= match_next;
            timer       <= timer_next;
            match_led   <= (timer_next != '0);
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param: default, non-overlap and small saturating/stretch builds.
`timescale 1ns/1ps
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic bit_a = 1'b0, vld_a = 1'b0, clr_a = 1'b0;
    logic bit_c = 1'b0, vld_c = 1'b0, clr_c = 1'b0;
    logic       load_a = 1'b0;
    logic [6:0] pin_a  = 7'b0;
    logic       load_off = 1'b0;
    logic [6:0] pin_b  = 7'b1100111;
    logic [1:0] pin_c  = 2'b10;

    logic       m_a, led_a, m_b, led_b, m_c, led_c;
    logic [2:0] prog_a, prog_b;
    logic [1:0] prog_c;
    logic [9:0] hist_a, hist_b;
    logic [3:0] hist_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int checks = 0;
    int errors = 0;

    seq_detect_param dut_a (
        .CLOCK_50(clk), .KEY0(rst_n),
`ifdef SEQ_DETECT_PATTERN_LOAD_EN
        .pat_load(load_a), .pat_in(pin_a),
`endif
        .bit_in(bit_a), .bit_valid(vld_a), .clr(clr_a),
        .match(m_a), .match_led(led_a), .progress(prog_a),
        .history(hist_a), .match_count(cnt_a)
    );

    seq_detect_param #(.OVERLAP(1'b0)) dut_b (
        .CLOCK_50(clk), .KEY0(rst_n),
`ifdef SEQ_DETECT_PATTERN_LOAD_EN
        .pat_load(load_off), .pat_in(pin_b),
`endif
        .bit_in(bit_a), .bit_valid(vld_a), .clr(clr_a),
        .match(m_b), .match_led(led_b), .progress(prog_b),
        .history(hist_b), .match_count(cnt_b)
    );

    seq_detect_param #(.PAT_W(2), .PATTERN(2'b10), .OVERLAP(1'b1), .HIST_W(4),
                       .CNT_W(2), .STRETCH(4)) dut_c (
        .CLOCK_50(clk), .KEY0(rst_n),
`ifdef SEQ_DETECT_PATTERN_LOAD_EN
        .pat_load(load_off), .pat_in(pin_c),
`endif
        .bit_in(bit_c), .bit_valid(vld_c), .clr(clr_c),
        .match(m_c), .match_led(led_c), .progress(prog_c),
        .history(hist_c), .match_count(cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; results are read 1ns after the next one.
    task automatic strobe_a(input logic b);
        bit_a = b;
        vld_a = 1'b1;
        @(posedge clk); #1;
        vld_a = 1'b0;
    endtask

    task automatic strobe_c(input logic b);
        bit_c = b;
        vld_c = 1'b1;
        @(posedge clk); #1;
        vld_c = 1'b0;
    endtask

    task automatic idle;
        @(posedge clk); #1;
    endtask

    logic [6:0] seq1 = 7'b1100111;
    logic [4:0] seq2 = 5'b00111;
    int exp_a2[5] = '{3, 4, 5, 6, 7};
    int exp_b2[5] = '{0, 0, 1, 2, 2};
    logic [4:0] seq3 = 5'b11100;
    int exp_a3[5] = '{1, 2, 2, 3, 4};
    int run;

    initial begin
        #12;
        check("rst_prog", prog_a, 0);
        check("rst_match", m_a, 0);
        check("rst_led", led_a, 0);
        check("rst_hist", hist_a, 0);
        check("rst_cnt", cnt_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();

        for (int j = 0; j < 7; j++) begin
            strobe_a(seq1[6-j]);
            check("prog_seq1", prog_a, j + 1);
            if (j < 6) check("nomatch_seq1", m_a, 0);
        end
        check("match1", m_a, 1);
        check("cnt1", cnt_a, 1);
        check("hist1", hist_a, 10'b0001100111);
        check("led1", led_a, 1);
        check("b_match1", m_b, 1);
        check("b_prog1", prog_b, 7);
        idle();
        check("match_pulse", m_a, 0);
        check("prog_hold", prog_a, 7);

        for (int j = 0; j < 5; j++) begin
            strobe_a(seq2[4-j]);
            check("prog_ovl", prog_a, exp_a2[j]);
            check("prog_novl", prog_b, exp_b2[j]);
        end
        check("match2", m_a, 1);
        check("cnt2", cnt_a, 2);
        check("hist2", hist_a, 10'b0011100111);
        check("b_nomatch", m_b, 0);
        check("b_cnt", cnt_b, 1);

        clr_a = 1'b1;
        idle();
        clr_a = 1'b0;
        check("clr_prog", prog_a, 0);
        check("clr_cnt", cnt_a, 0);
        check("clr_hist", hist_a, 0);
        check("clr_keeps_led", led_a, 1);

        for (int j = 0; j < 5; j++) begin
            strobe_a(seq3[4-j]);
            check("prog_fallback", prog_a, exp_a3[j]);
        end

        clr_a = 1'b1;
        strobe_a(1'b1);
        clr_a = 1'b0;
        check("clrbv_prog", prog_a, 0);
        check("clrbv_hist", hist_a, 0);

        strobe_a(1'b1); strobe_a(1'b1); strobe_a(1'b0); strobe_a(1'b0);
        check("prog_mid", prog_a, 4);
        rst_n = 1'b0;
        #1;
        check("arst_prog", prog_a, 0);
        check("arst_hist", hist_a, 0);
        check("arst_cnt", cnt_a, 0);
        check("arst_led", led_a, 0);
        check("arst_match", m_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        strobe_a(1'b0);
        check("post_rst_prog", prog_a, 0);

`ifdef SEQ_DETECT_PATTERN_LOAD_EN
        strobe_a(1'b1); strobe_a(1'b1);
        check("preload_prog", prog_a, 2);
        pin_a  = 7'b1010101;
        load_a = 1'b1;
        idle();
        load_a = 1'b0;
        check("load_prog", prog_a, 0);
        for (int j = 0; j < 7; j++) begin
            strobe_a(pin_a[6-j]);
            check("prog_loaded", prog_a, j + 1);
        end
        check("match_loaded", m_a, 1);
`endif

        strobe_c(1'b1);
        check("c_prog1", prog_c, 1);
        check("c_led0", led_c, 0);
        run = 0;
        strobe_c(1'b0);
        check("c_match1", m_c, 1);
        if (led_c) run++;
        strobe_c(1'b1);
        check("c_prog_fb", prog_c, 1);
        if (led_c) run++;
        strobe_c(1'b0);
        check("c_match2", m_c, 1);
        check("c_cnt2", cnt_c, 2);
        if (led_c) run++;
        for (int j = 0; j < 3; j++) begin
            idle();
            if (led_c) run++;
        end
        idle();
        check("c_led_off", led_c, 0);
        check("c_led_run", run, 6);

        for (int j = 0; j < 3; j++) begin
            strobe_c(1'b1);
            strobe_c(1'b0);
        end
        check("c_cnt_sat", cnt_c, 3);
        check("c_match_sat", m_c, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial-pattern detector, the successor to the fixed 7-bit detector on the DE-board labs.
- Accepts one bit per qualified sample from a debounced, edge-detected key strobe, not a raw key clock.
- Tracks how far into the pattern the input currently is, with selectable overlapping or non-overlapping match semantics.
- Pulses and stretches a match indication, counts matches, and exposes recent input history for the LEDs.

Parameters:
- PAT_W, 7: pattern length in bits, 2..16.
- PATTERN, 7'b1100111: target sequence; the MSB is the first bit received.
- OVERLAP, 1: 1 = matches may share bits; 0 = matching restarts from empty after each match.
- HIST_W, 10: width of the input-history shift register.
- CNT_W, 8: width of the match counter.
- STRETCH, 25000000: number of cycles match_led stays high after a match; minimum 1.

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- KEY0  in  1  asynchronous active-low reset.
- bit_in  in  1  serial data bit, sampled only when bit_valid=1.
- bit_valid  in  1  single-cycle strobe qualifying bit_in.
- clr  in  1  synchronous clear of progress, history and count.
- match  out  1  one-cycle pulse on pattern completion.
- match_led  out  1  stretched match indication.
- progress  out  $clog2(PAT_W+1)  current matched-prefix length, 0..PAT_W.
- history  out  HIST_W  last HIST_W accepted bits; LSB is the newest.
- match_count  out  CNT_W  number of matches, saturating.

Behaviour:
- Reset (KEY0=0, asynchronous): progress=0, match=0, match_led=0, history=0, match_count=0, stretch timer=0, internal window-valid count=0.
- All outputs are registered and update in the cycle after the bit_valid sample (latency 1). Nothing changes while bit_valid=0, except the stretch timer.
- Internal window: the last PAT_W accepted bits plus a valid count vcnt (0..PAT_W), which counts bits accepted since the last restart.
- On an accepted bit:
  - history shifts left, with bit_in entering at the LSB.
  - window shifts in the same way; vcnt = min(vcnt+1, PAT_W).
  - next progress k = largest k <= vcnt such that the newest k window bits equal PATTERN[PAT_W-1 -: k]; k=0 if there is none.
- Progress is therefore a KMP-equivalent state machine with PAT_W+1 states (0..PAT_W). Mismatch fallback is the longest suffix/prefix overlap, not a return to 0.
- Match: when k==PAT_W, match=1 for exactly one cycle, and match_count increments, holding at 2^CNT_W-1.
- After a match, depending on OVERLAP:
  - OVERLAP=1: progress shows PAT_W for that cycle and the window is retained, so the next bit can continue from the overlap.
  - OVERLAP=0: progress shows PAT_W for that cycle and vcnt:=0, so the next bit starts from empty.
- match_led:
  - A match loads the timer with STRETCH; match_led=1 while the timer is nonzero.
  - The timer decrements every cycle.
  - A new match while the timer is running reloads it to STRETCH (retrigger).
- clr=1: progress=0, vcnt=0, history=0, match_count=0, match=0.
  - clr does not affect the stretch timer.
  - clr has priority over a simultaneous bit_valid, and that bit is dropped.
- A reset asserted mid-sequence aborts immediately; no partial match survives.
- Any bit value on bit_in while bit_valid=0 is ignored.

Optional Feature:
- Macro: SEQ_DETECT_PATTERN_LOAD_EN.
- When defined:
  - Extra ports pat_load (in, 1) and pat_in (in, PAT_W) are present.
  - The active pattern is a register, reset to PATTERN.
  - pat_load=1 loads pat_in and forces progress=0 and vcnt=0; history and match_count are kept.
  - pat_load has priority over bit_valid in the same cycle and is lower priority than clr.
- When undefined: these ports do not exist and the pattern is the constant PATTERN.

Test Plan:
- Defaults (OVERLAP=1); bits 1,1,0,0,1,1,1 -> progress steps 1,2,3,4,5,6,7; match is high one cycle after the 7th strobe; match_count=1; history=10'b0001100111.
- OVERLAP=1; 1100111 then 00111 -> second match after the 5th extra bit; match_count=2.
- OVERLAP=0; same 12 bits -> only one match; final progress=2.
- Bits 1,1,1 -> progress goes 1,2,2 (fallback, not 0); then 0 -> progress=3.
- Run with CNT_W=2 and 5 matches -> match_count holds at 3. Run with STRETCH=4 and two matches 2 cycles apart -> match_led stays high for 6 continuous cycles.
- Mid-sequence (progress=4):
  - KEY0 low -> all outputs 0 immediately.
  - clr together with bit_valid -> progress=0 and the bit is not shifted into history.
  - With SEQ_DETECT_PATTERN_LOAD_EN: load pat_in=7'b1010101 and feed 1010101 -> match.
